// File: rtl/status_reg.sv
// status_reg: 6502 processor status (P) register.
// Merges ALU flags, flag-set/clear instructions, PLP/RTI loads, BIT, interrupt
// entry and the SO pin into the architectural N V - B D I Z C state.
// Build option: define SO_PIN_EN to build the set-overflow synchronizer,
// edge detector and deferred-set logic; otherwise so_n is ignored.
module status_reg #(
  parameter int SO_SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic       plp,
  input  logic [7:0] db_in,
  input  logic       flag_we,
  input  logic [2:0] flag_op,
  input  logic       set_i,
  input  logic       instr_done,
  input  logic       brk_push,
  input  logic       so_n,
  output logic [7:0] p_out,
  output logic       c_out,
  output logic       d_out,
  output logic       i_mask
);

  localparam logic [2:0] OP_CLC = 3'b000;
  localparam logic [2:0] OP_SEC = 3'b001;
  localparam logic [2:0] OP_CLI = 3'b010;
  localparam logic [2:0] OP_SEI = 3'b011;
  localparam logic [2:0] OP_CLD = 3'b100;
  localparam logic [2:0] OP_SED = 3'b101;
  localparam logic [2:0] OP_CLV = 3'b110;

  logic n_q, n_d;
  logic v_q, v_d;
  logic d_q, d_d;
  logic i_q, i_d;
  logic z_q, z_d;
  logic c_q, c_d;
  logic imask_q, imask_d;

  logic opClc, opSec, opCli, opSei, opCld, opSed, opClv;
  logic vWriter;
  logic vWriteVal;
  logic soSetV;

  // Decode the flag-set/clear instruction, gated by its write enable.
  always_comb begin
    opClc = flag_we && (flag_op == OP_CLC);
    opSec = flag_we && (flag_op == OP_SEC);
    opCli = flag_we && (flag_op == OP_CLI);
    opSei = flag_we && (flag_op == OP_SEI);
    opCld = flag_we && (flag_op == OP_CLD);
    opSed = flag_we && (flag_op == OP_SED);
    opClv = flag_we && (flag_op == OP_CLV);
  end

  // Resolve the V writers in priority order; SO only acts when none is active.
  always_comb begin
    vWriter   = plp || opClv || bit_op || upd_v;
    vWriteVal = v_q;
    if (plp) begin
      vWriteVal = db_in[6];
    end else if (opClv) begin
      vWriteVal = 1'b0;
    end else if (bit_op) begin
      vWriteVal = db_in[6];
    end else if (upd_v) begin
      vWriteVal = alu_v;
    end
  end

`ifdef SO_PIN_EN
  logic [SO_SYNC_STAGES-1:0] soSync_q;
  logic                      soHist_q;
  logic                      soPend_q, soPend_d;
  logic                      soLast;
  logic                      soFall;

  assign soLast = soSync_q[SO_SYNC_STAGES-1];
  assign soFall = soHist_q & ~soLast;

  // Synchronize the asynchronous SO pin and keep one history bit for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soSync_q <= '1;
      soHist_q <= 1'b1;
    end else begin
      soSync_q <= {soSync_q[SO_SYNC_STAGES-2:0], so_n};
      soHist_q <= soLast;
    end
  end

  // A falling edge sets V, or is held pending while an instruction owns V.
  always_comb begin
    soPend_d = soPend_q;
    soSetV   = 1'b0;
    if (soFall || soPend_q) begin
      if (vWriter) begin
        soPend_d = 1'b1;
      end else begin
        soSetV   = 1'b1;
        soPend_d = 1'b0;
      end
    end
  end

  // Pending SO request register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      soPend_q <= 1'b0;
    end else begin
      soPend_q <= soPend_d;
    end
  end
`else
  logic        so_unused;
  logic [31:0] so_stages_unused;

  assign so_unused        = so_n;
  assign so_stages_unused = SO_SYNC_STAGES;
  assign soSetV           = 1'b0;
`endif

  // Next-state for each flag: each bit takes its highest-priority writer.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;

    if (plp) begin
      n_d = db_in[7];
    end else if (bit_op) begin
      n_d = db_in[7];
    end else if (upd_nz) begin
      n_d = alu_n;
    end

    if (vWriter) begin
      v_d = vWriteVal;
    end else if (soSetV) begin
      v_d = 1'b1;
    end

    if (plp) begin
      d_d = db_in[3];
    end else if (opCld) begin
      d_d = 1'b0;
    end else if (opSed) begin
      d_d = 1'b1;
    end

    if (plp) begin
      i_d = db_in[2];
    end else if (set_i) begin
      i_d = 1'b1;
    end else if (opCli) begin
      i_d = 1'b0;
    end else if (opSei) begin
      i_d = 1'b1;
    end

    if (plp) begin
      z_d = db_in[1];
    end else if (bit_op || upd_nz) begin
      z_d = alu_z;
    end

    if (plp) begin
      c_d = db_in[0];
    end else if (opClc) begin
      c_d = 1'b0;
    end else if (opSec) begin
      c_d = 1'b1;
    end else if (upd_c) begin
      c_d = alu_co;
    end

    imask_d = instr_done ? i_q : imask_q;
  end

  // Architectural flag registers and the boundary-delayed interrupt mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      d_q     <= 1'b0;
      i_q     <= 1'b1;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      imask_q <= 1'b1;
    end else begin
      n_q     <= n_d;
      v_q     <= v_d;
      d_q     <= d_d;
      i_q     <= i_d;
      z_q     <= z_d;
      c_q     <= c_d;
      imask_q <= imask_d;
    end
  end

  assign p_out  = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign c_out  = c_q;
  assign d_out  = d_q;
  assign i_mask = imask_q;

endmodule
